cdp_access_ctrl: RTL
====================

// Module: cdp_access_ctrl
// PURPOSE
// Sequences debug accesses decoded by the Core Debug Port onto the memory bus of the Core Debug logic.
// - Accepts one decoded command per Update-DR pulse.
// - Holds the SELECT and TADDR registers.
// - Runs a single-outstanding bus transaction for DTR accesses, with timeout.
// - Returns {ack, result} for the next Capture-DR.
// - Sits between the CDPACC scan register and the core debug bus slave; all logic runs on the JTAG clock.
// PARAMETERS
// ADDR_W    32   width of bus_addr and TADDR
// TIMEOUT   256  bus_ready wait limit in tck cycles (>=2)
// ADDR_INC  4    TADDR increment after a DTR access when SELECT[0]=1
// PORTS
// tck        in   1       test clock; single clock domain
// trst       in   1       test reset; asynchronous, active-high
// cmd_valid  in   1       1-cycle pulse: decoded command present (Update-DR, IR==CDPACC)
// cmd_wr     in   1       1=write, 0=read
// cmd_op     in   3       0=SELECT, 1=TADDR, 2=DTR; 3..7 invalid
// cmd_data   in   32      write data
// bus_req    out  1       bus request; held until bus_ready or timeout
// bus_we     out  1       1=write transaction
// bus_addr   out  ADDR_W  transaction address (=TADDR at issue)
// bus_wdata  out  32      write data
// bus_rdata  in   32      read data, valid with bus_ready
// bus_ready  in   1       transaction complete (1 cycle)
// bus_err    in   1       error, qualified by bus_ready
// result     out  32      data returned at next Capture-DR
// ack        out  4       0001 OK, 0010 WAIT, 0100 FAULT, 1000 INVALID
// overrun    out  1       sticky: a command was dropped while busy
// busy       out  1       bus transaction in progress
// BEHAVIOUR
// Reset (trst=1, asynchronous):
// - bus_req/bus_we/busy/overrun=0; bus_addr/bus_wdata/result=0; ack=0001; SELECT=0; TADDR=0.
// - Reset mid-transaction drops bus_req immediately; no completion is recorded.
// FSM IDLE/BUS. In IDLE, on cmd_valid (command at cycle N; all updates at N+1):
// - SELECT wr: SELECT<=cmd_data; if cmd_data[31]=1, overrun<=0; ack<=0001; result unchanged.
// - TADDR wr: TADDR<=cmd_data[ADDR_W-1:0] (zero-extended if ADDR_W>32); ack<=0001.
// - SELECT/TADDR rd: result<=register, zero-extended/truncated to 32; ack<=0001.
// - DTR wr/rd: ->BUS; busy=1; bus_req=1; bus_addr=TADDR; bus_we=cmd_wr; bus_wdata=cmd_data (wr); ack<=0010.
// - op 3..7: ack<=1000; no other state change.
// In BUS:
// - bus_req/bus_we/bus_addr/bus_wdata held stable until exit.
// - Timeout counter clears on entry and increments each cycle.
// - bus_ready & !bus_err: ack<=0001; result<=bus_rdata if read; if SELECT[0], TADDR<=TADDR+ADDR_INC (wraps mod 2^ADDR_W); ->IDLE.
// - bus_ready & bus_err: ack<=0100; result and TADDR unchanged; ->IDLE.
// - TIMEOUT cycles in BUS without bus_ready: bus_req<=0, ack<=0100, ->IDLE.
// - Exit: bus_req and busy drop the cycle after bus_ready.
// - cmd_valid while in BUS, including the bus_ready cycle: command dropped; overrun<=1; ack stays 0010 until completion.
// - bus_ready outside BUS is ignored.
// Minimum DTR latency: cmd_valid at N, bus_req at N+1, bus_ready at N+1, ack/result valid at N+2.
// TESTING
// - Reset, TADDR wr 0x1000, DTR wr 0xCAFE, bus_ready after 3 cycles -> bus_addr=0x1000, bus_we=1, ack 0010 then 0001.
// - SELECT wr 1, TADDR wr 0x2000, two DTR reads (rdata 0x11, 0x22) -> addresses 0x2000/0x2004, result 0x22, TADDR rd=0x2008.
// - DTR rd, bus never ready -> bus_req falls after 256 cycles, ack=0100, busy=0.
// - DTR wr, second cmd_valid 1 cycle later -> second command dropped, overrun=1; SELECT wr 0x80000000 -> overrun=0.
// - bus_ready with bus_err=1 -> ack=0100, TADDR not incremented; cmd_op=5 -> ack=1000, registers unchanged.
// - trst asserted while bus_req=1 -> bus_req=0 asynchronously, ack=0001, SELECT/TADDR=0.

Source files
------------

// File: rtl/cdp_access_ctrl.sv
// Core Debug Port access controller.
// Accepts one decoded CDPACC command per Update-DR pulse, holds the SELECT and
// TADDR registers, runs a single-outstanding debug bus transaction for DTR
// accesses (with a timeout), and presents {ack, result} for the next Capture-DR.
module cdp_access_ctrl #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned TIMEOUT  = 256,
    parameter int unsigned ADDR_INC = 4
) (
    input  logic              tck,
    input  logic              trst,
    input  logic              cmd_valid,
    input  logic              cmd_wr,
    input  logic [2:0]        cmd_op,
    input  logic [31:0]       cmd_data,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ready,
    input  logic              bus_err,
    output logic [31:0]       result,
    output logic [3:0]        ack,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    localparam logic [3:0] ACK_OK      = 4'b0001;
    localparam logic [3:0] ACK_WAIT    = 4'b0010;
    localparam logic [3:0] ACK_FAULT   = 4'b0100;
    localparam logic [3:0] ACK_INVALID = 4'b1000;

    typedef enum logic [2:0] {
        OP_SELECT = 3'd0,
        OP_TADDR  = 3'd1,
        OP_DTR    = 3'd2
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUS  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        sel_q, sel_d;
    logic [ADDR_W-1:0]  taddr_q, taddr_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        result_q, result_d;
    logic [3:0]         ack_q, ack_d;
    logic               ovr_q, ovr_d;

    // Register all controller state; trst clears everything asynchronously,
    // which also drops an in-flight bus request without recording completion.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            taddr_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            ack_q    <= ACK_OK;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            taddr_q  <= taddr_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            result_q <= result_d;
            ack_q    <= ack_d;
            ovr_q    <= ovr_d;
        end
    end

    // Next-state: command decode in IDLE, completion/timeout/overrun in BUS.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        taddr_d  = taddr_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        result_d = result_q;
        ack_d    = ack_q;
        ovr_d    = ovr_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_SELECT: begin
                            ack_d = ACK_OK;
                            if (cmd_wr) begin
                                sel_d = cmd_data;
                                if (cmd_data[31]) begin
                                    ovr_d = 1'b0;
                                end
                            end else begin
                                result_d = sel_q;
                            end
                        end
                        OP_TADDR: begin
                            ack_d = ACK_OK;
                            if (cmd_wr) begin
                                taddr_d = ADDR_W'(cmd_data);
                            end else begin
                                result_d = 32'(taddr_q);
                            end
                        end
                        OP_DTR: begin
                            state_d = S_BUS;
                            cnt_d   = '0;
                            addr_d  = taddr_q;
                            we_d    = cmd_wr;
                            if (cmd_wr) begin
                                wdata_d = cmd_data;
                            end
                            ack_d   = ACK_WAIT;
                        end
                        default: begin
                            ack_d = ACK_INVALID;
                        end
                    endcase
                end
            end
            S_BUS: begin
                cnt_d = cnt_q + 1'b1;
                if (cmd_valid) begin
                    ovr_d = 1'b1;
                end
                // A response on the final timeout cycle still counts as completion.
                if (bus_ready) begin
                    state_d = S_IDLE;
                    if (bus_err) begin
                        ack_d = ACK_FAULT;
                    end else begin
                        ack_d = ACK_OK;
                        if (!we_q) begin
                            result_d = bus_rdata;
                        end
                        if (sel_q[0]) begin
                            taddr_d = taddr_q + ADDR_W'(ADDR_INC);
                        end
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    ack_d   = ACK_FAULT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // bus_req and busy are the same condition: a transaction is outstanding.
    always_comb begin
        bus_req   = (state_q == S_BUS);
        busy      = (state_q == S_BUS);
        bus_we    = we_q;
        bus_addr  = addr_q;
        bus_wdata = wdata_q;
        result    = result_q;
        ack       = ack_q;
        overrun   = ovr_q;
    end

endmodule
